// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : Y86-64 data-memory responder, fixed latency, 8-byte LE access
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [63:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_error_o,
  output logic              busy_o
);

  localparam int          NBYTES   = DATA_W / 8;
  localparam int          ADDR_W   = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - NBYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic                bad_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                resp_error_q;

  logic [7:0]          mem [MEM_BYTES];
  logic [DATA_W-1:0]   mem_rd;
  logic                mem_we;

  assign req_ready_o  = (state_q == S_IDLE) && !rst;
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = resp_error_q;

  // Out-of-range accesses may wrap the byte index; the result is discarded then.
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < NBYTES; i++) begin
      mem_rd[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
    end
  end

  assign mem_we = (state_q == S_COMMIT) && write_q && !bad_q && !rst;

  // Storage has no reset: contents survive rst, only in-flight writes are lost.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        mem[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      bad_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            bad_q   <= (req_addr_i > LAST_OK);
            addr_q  <= req_addr_i[ADDR_W-1:0];
            wdata_q <= req_wdata_i;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? S_COMMIT : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          resp_valid_q <= 1'b1;
          resp_error_q <= bad_q;
          rdata_q      <= (write_q || bad_q) ? '0 : mem_rd;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rdata_q      <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed table, corner sequences and random traffic
// Revision 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int LATENCY   = 2;
  localparam int MEM_BYTES = 1024;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error, busy;
  logic [63:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  logic [7:0] mdl [MEM_BYTES];

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  dmem_responder #(.DATA_W(64), .MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_error_o(resp_error),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: flat byte array, little-endian, range check on the full address.
  task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er);
    rd = '0;
    er = (a > 64'(MEM_BYTES - 8));
    if (!er) begin
      for (int i = 0; i < 8; i++) begin
        if (w) mdl[int'(a) + i] = d[8*i +: 8];
        else   rd[8*i +: 8] = mdl[int'(a) + i];
      end
    end
  endtask

  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    step();
    accept_cyc = cyc;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input int stall, output logic [63:0] rd, output logic er);
    int lat;
    issue(w, a, d);
    wait_resp(lat);
    chk("latency", 64'(lat), 64'(LATENCY));
    if (stall > 0) begin
      resp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_hold_valid", 64'(resp_valid), 64'd1);
      end
    end
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    step();
    chk("post_handshake_valid", 64'(resp_valid), 64'd0);
    chk("post_handshake_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    vec_t        tbl [$];
    logic [63:0] rd, erd, held, rsp, v;
    logic        er, eer;
    logic [63:0] stack [$];
    int          prev;
    int          lat;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h00;
    step(); step();
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_rdata",      resp_rdata,      64'd0);
    chk("rst_error",      64'(resp_error), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Zero-fill memory so reference and DUT start identical.
    for (int a = 0; a < MEM_BYTES; a += 8) txn(1'b1, 64'(a), 64'd0, 0, rd, er);

    tbl.push_back('{1'b1, 64'h100, 64'h0123456789ABCDEF, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'h100, 64'd0, 64'h0123456789ABCDEF, 1'b0});
    tbl.push_back('{1'b1, 64'h0,   64'h1122334455667788, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'h3,   64'd0, 64'h0000001122334455, 1'b0});
    tbl.push_back('{1'b0, 64'h0,   64'd0, 64'h1122334455667788, 1'b0});
    tbl.push_back('{1'b1, 64'h3F8, 64'hCAFEF00DBAADBEEF, 64'd0, 1'b0});
    tbl.push_back('{1'b1, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'h3F8, 64'd0, 64'hCAFEF00DBAADBEEF, 1'b0});
    tbl.push_back('{1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1});
    tbl.push_back('{1'b1, 64'h400, 64'h5A5A5A5A5A5A5A5A, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'h8000000000000100, 64'd0, 64'd0, 1'b1});
    tbl.push_back('{1'b0, 64'h3F8, 64'd0, 64'hCAFEF00DBAADBEEF, 1'b0});
    foreach (tbl[k]) begin
      txn(tbl[k].w, tbl[k].a, tbl[k].d, 0, rd, er);
      chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp_rd);
      chk($sformatf("tbl%0d_error", k), 64'(er), 64'(tbl[k].exp_err));
      model(tbl[k].w, tbl[k].a, tbl[k].d, erd, eer);
    end

    // Response held while the requester stalls.
    resp_ready = 1'b0;
    issue(1'b0, 64'h100, 64'd0);
    wait_resp(lat);
    chk("stall_latency", 64'(lat), 64'(LATENCY));
    held = resp_rdata;
    chk("stall_rdata", held, 64'h0123456789ABCDEF);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_rdata_stable", resp_rdata, held);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("stall_release_valid", 64'(resp_valid), 64'd0);
    chk("stall_release_ready", 64'(req_ready), 64'd1);

    // Async reset kills an in-flight write.
    txn(1'b1, 64'h40, 64'h0BADF00D12345678, 0, rd, er);
    model(1'b1, 64'h40, 64'h0BADF00D12345678, erd, eer);
    issue(1'b1, 64'h40, 64'h000000000000DEAD);
    step();
    chk("inflight_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_ready",  64'(req_ready),  64'd0);
    chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_busy",       64'(busy),       64'd0);
    chk("async_rst_rdata",      resp_rdata,      64'd0);
    chk("async_rst_error",      64'(resp_error), 64'd0);
    step();
    rst = 1'b0;
    step();
    txn(1'b0, 64'h40, 64'd0, 0, rd, er);
    model(1'b0, 64'h40, 64'd0, erd, eer);
    chk("after_rst_rdata", rd, erd);
    chk("after_rst_error", 64'(er), 64'd0);

    // pushq/popq stream: LIFO data, one accept every LATENCY+2 cycles.
    rsp = 64'h200;
    for (int i = 0; i < 8; i++) begin
      prev = accept_cyc;
      rsp = rsp - 64'd8;
      v = {$urandom, $urandom};
      stack.push_back(v);
      txn(1'b1, rsp, v, 0, rd, er);
      model(1'b1, rsp, v, erd, eer);
      if (i > 0) chk("push_interval", 64'(accept_cyc - prev), 64'(LATENCY + 2));
    end
    for (int i = 0; i < 8; i++) begin
      prev = accept_cyc;
      txn(1'b0, rsp, 64'd0, 0, rd, er);
      model(1'b0, rsp, 64'd0, erd, eer);
      rsp = rsp + 64'd8;
      chk("pop_lifo", rd, stack.pop_back());
      chk("pop_interval", 64'(accept_cyc - prev), 64'(LATENCY + 2));
    end

    // Random traffic against the byte-array reference.
    for (int n = 0; n < 80; n++) begin
      logic        w;
      logic [63:0] a, d;
      int          sel;
      w   = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 64'($urandom_range(0, MEM_BYTES - 8));
      else if (sel < 9) a = 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES + 4));
      else              a = {$urandom, $urandom} | 64'h1_0000_0000;
      d = {$urandom, $urandom};
      txn(w, a, d, $urandom_range(0, 3), rd, er);
      model(w, a, d, erd, eer);
      chk($sformatf("rand%0d_rdata", n), rd, erd);
      chk($sformatf("rand%0d_error", n), 64'(er), 64'(eer));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
